// File: rtl/id_stage_pkg.sv
// Shared decode constants and control bundle types
// for the instruction-decode stage.
package id_stage_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

endpackage

// File: rtl/id_stage_reg_file.sv
// Register file: two combinational read ports with write-first
// bypass, one synchronous write port, synchronous clear.
module reg_file #(
    parameter int RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [RF_DEPTH];
    logic        wr_ok;

    assign wr_ok = we && (waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Register 0 reads as zero regardless of storage or bypass.
    always_comb begin
        rdata1 = 32'd0;
        rdata2 = 32'd0;
        if (raddr1 != 5'd0) begin
            rdata1 = (wr_ok && waddr == raddr1) ? wdata : regs[raddr1];
        end
        if (raddr2 != 5'd0) begin
            rdata2 = (wr_ok && waddr == raddr2) ? wdata : regs[raddr2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode: control generation, operand read,
// sign extension, and the ID/EX pipeline latch.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_ID_instr,
    input  logic [31:0] IF_ID_npc,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_WriteReg,
    input  logic [31:0] MEM_WB_WriteData,
    output logic [1:0]  ID_EX_wb,
    output logic [2:0]  ID_EX_m,
    output logic [3:0]  ID_EX_ex,
    output logic [31:0] ID_EX_npc,
    output logic [31:0] ID_EX_readdat1,
    output logic [31:0] ID_EX_readdat2,
    output logic [31:0] ID_EX_sign_ext,
    output logic [4:0]  ID_EX_instr_2016,
    output logic [4:0]  ID_EX_instr_1511
);

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    ctrl_t       ctrl;

    assign opcode = IF_ID_instr[31:26];
    assign rs     = IF_ID_instr[25:21];
    assign rt     = IF_ID_instr[20:16];
    assign rd     = IF_ID_instr[15:11];
    assign sext   = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};

    reg_file #(
        .RF_DEPTH(RF_DEPTH)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (MEM_WB_RegWrite),
        .waddr (MEM_WB_WriteReg),
        .wdata (MEM_WB_WriteData),
        .raddr1(rs),
        .raddr2(rt),
        .rdata1(rd1),
        .rdata2(rd2)
    );

    // Unknown opcodes decode to all-zero control, i.e. a bubble.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.wb = 2'b10;
                ctrl.m  = 3'b000;
                ctrl.ex = {1'b1, ALUOP_FUNCT, 1'b0};
            end
            OP_LW: begin
                ctrl.wb = 2'b11;
                ctrl.m  = 3'b010;
                ctrl.ex = {1'b0, ALUOP_ADD, 1'b1};
            end
            OP_SW: begin
                ctrl.wb = 2'b00;
                ctrl.m  = 3'b001;
                ctrl.ex = {1'b0, ALUOP_ADD, 1'b1};
            end
            OP_BEQ: begin
                ctrl.wb = 2'b00;
                ctrl.m  = 3'b100;
                ctrl.ex = {1'b0, ALUOP_SUB, 1'b0};
            end
            default: ctrl = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ID_EX_wb         <= '0;
            ID_EX_m          <= '0;
            ID_EX_ex         <= '0;
            ID_EX_npc        <= '0;
            ID_EX_readdat1   <= '0;
            ID_EX_readdat2   <= '0;
            ID_EX_sign_ext   <= '0;
            ID_EX_instr_2016 <= '0;
            ID_EX_instr_1511 <= '0;
        end else begin
            ID_EX_wb         <= ctrl.wb;
            ID_EX_m          <= ctrl.m;
            ID_EX_ex         <= ctrl.ex;
            ID_EX_npc        <= IF_ID_npc;
            ID_EX_readdat1   <= rd1;
            ID_EX_readdat2   <= rd2;
            ID_EX_sign_ext   <= sext;
            ID_EX_instr_2016 <= rt;
            ID_EX_instr_1511 <= rd;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with hand-computed
// expected values.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteReg;
    logic [31:0] MEM_WB_WriteData;
    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc;
    logic [31:0] ID_EX_readdat1;
    logic [31:0] ID_EX_readdat2;
    logic [31:0] ID_EX_sign_ext;
    logic [4:0]  ID_EX_instr_2016;
    logic [4:0]  ID_EX_instr_1511;

    int total = 0;
    int bad   = 0;

    id_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_ID_instr     (IF_ID_instr),
        .IF_ID_npc       (IF_ID_npc),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .MEM_WB_WriteReg (MEM_WB_WriteReg),
        .MEM_WB_WriteData(MEM_WB_WriteData),
        .ID_EX_wb        (ID_EX_wb),
        .ID_EX_m         (ID_EX_m),
        .ID_EX_ex        (ID_EX_ex),
        .ID_EX_npc       (ID_EX_npc),
        .ID_EX_readdat1  (ID_EX_readdat1),
        .ID_EX_readdat2  (ID_EX_readdat2),
        .ID_EX_sign_ext  (ID_EX_sign_ext),
        .ID_EX_instr_2016(ID_EX_instr_2016),
        .ID_EX_instr_1511(ID_EX_instr_1511)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_set(input logic we, input logic [4:0] a,
                          input logic [31:0] d);
        MEM_WB_RegWrite  = we;
        MEM_WB_WriteReg  = a;
        MEM_WB_WriteData = d;
    endtask

    initial begin
        logic [4:0] r;

        // Reset with a write-back that must be dropped
        rst_n       = 1'b0;
        IF_ID_instr = 32'h8C220004;
        IF_ID_npc   = 32'h55;
        wb_set(1'b1, 5'd1, 32'h0000FFFF);
        step();
        step();
        check("rst_wb",   {30'd0, ID_EX_wb}, 32'd0);
        check("rst_m",    {29'd0, ID_EX_m}, 32'd0);
        check("rst_ex",   {28'd0, ID_EX_ex}, 32'd0);
        check("rst_npc",  ID_EX_npc, 32'd0);
        check("rst_rd1",  ID_EX_readdat1, 32'd0);
        check("rst_rd2",  ID_EX_readdat2, 32'd0);
        check("rst_sext", ID_EX_sign_ext, 32'd0);
        check("rst_rt",   {27'd0, ID_EX_instr_2016}, 32'd0);
        check("rst_rd",   {27'd0, ID_EX_instr_1511}, 32'd0);

        // Every register reads zero after reset
        rst_n = 1'b1;
        wb_set(1'b0, 5'd0, 32'd0);
        for (int i = 1; i < 32; i++) begin
            r = i[4:0];
            IF_ID_instr = {6'h00, r, r, 16'h0000};
            step();
            check($sformatf("clr_rs%0d", i), ID_EX_readdat1, 32'd0);
            check($sformatf("clr_rt%0d", i), ID_EX_readdat2, 32'd0);
        end

        // Write reg2=7, reg3=5, then add $1,$2,$3
        IF_ID_instr = 32'd0;
        wb_set(1'b1, 5'd2, 32'd7);
        step();
        wb_set(1'b1, 5'd3, 32'd5);
        step();
        wb_set(1'b0, 5'd0, 32'd0);
        IF_ID_instr = 32'h00430820;
        IF_ID_npc   = 32'd4;
        step();
        check("add_wb",  {30'd0, ID_EX_wb}, 32'b10);
        check("add_m",   {29'd0, ID_EX_m}, 32'b000);
        check("add_ex",  {28'd0, ID_EX_ex}, 32'b1100);
        check("add_rd1", ID_EX_readdat1, 32'd7);
        check("add_rd2", ID_EX_readdat2, 32'd5);
        check("add_rt",  {27'd0, ID_EX_instr_2016}, 32'd3);
        check("add_rd",  {27'd0, ID_EX_instr_1511}, 32'd1);
        check("add_npc", ID_EX_npc, 32'd4);

        // lw $2,-4($1); reg1 was never written
        IF_ID_instr = 32'h8C22FFFC;
        IF_ID_npc   = 32'd5;
        step();
        check("lw_sext", ID_EX_sign_ext, 32'hFFFFFFFC);
        check("lw_wb",   {30'd0, ID_EX_wb}, 32'b11);
        check("lw_m",    {29'd0, ID_EX_m}, 32'b010);
        check("lw_ex",   {28'd0, ID_EX_ex}, 32'b0001);
        check("lw_rd1",  ID_EX_readdat1, 32'd0);
        check("lw_rd2",  ID_EX_readdat2, 32'd7);
        check("lw_rt",   {27'd0, ID_EX_instr_2016}, 32'd2);
        check("lw_rd",   {27'd0, ID_EX_instr_1511}, 32'd31);

        // sw $5,0($4) with same-cycle write of reg5
        IF_ID_instr = 32'hAC850000;
        IF_ID_npc   = 32'd6;
        wb_set(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        check("sw_rd2",  ID_EX_readdat2, 32'hDEADBEEF);
        check("sw_rd1",  ID_EX_readdat1, 32'd0);
        check("sw_m",    {29'd0, ID_EX_m}, 32'b001);
        check("sw_wb",   {30'd0, ID_EX_wb}, 32'b00);
        check("sw_ex",   {28'd0, ID_EX_ex}, 32'b0001);
        check("sw_sext", ID_EX_sign_ext, 32'd0);

        // Bypassed value also committed to storage
        wb_set(1'b0, 5'd0, 32'd0);
        IF_ID_instr = 32'h00A50000;
        step();
        check("commit_rd1", ID_EX_readdat1, 32'hDEADBEEF);
        check("commit_rd2", ID_EX_readdat2, 32'hDEADBEEF);

        // beq reading reg0 while reg0 is written
        IF_ID_instr = 32'h10000003;
        IF_ID_npc   = 32'd8;
        wb_set(1'b1, 5'd0, 32'h1234);
        step();
        check("beq_rd1",  ID_EX_readdat1, 32'd0);
        check("beq_rd2",  ID_EX_readdat2, 32'd0);
        check("beq_m",    {29'd0, ID_EX_m}, 32'b100);
        check("beq_ex",   {28'd0, ID_EX_ex}, 32'b0010);
        check("beq_wb",   {30'd0, ID_EX_wb}, 32'b00);
        check("beq_sext", ID_EX_sign_ext, 32'd3);
        wb_set(1'b0, 5'd0, 32'd0);
        step();
        check("r0_after", ID_EX_readdat1, 32'd0);

        // Unknown opcode 0x3F is a bubble but data still latches
        IF_ID_instr = 32'hFC438001;
        IF_ID_npc   = 32'h99;
        step();
        check("unk_wb",   {30'd0, ID_EX_wb}, 32'd0);
        check("unk_m",    {29'd0, ID_EX_m}, 32'd0);
        check("unk_ex",   {28'd0, ID_EX_ex}, 32'd0);
        check("unk_npc",  ID_EX_npc, 32'h99);
        check("unk_rd1",  ID_EX_readdat1, 32'd7);
        check("unk_rd2",  ID_EX_readdat2, 32'd5);
        check("unk_sext", ID_EX_sign_ext, 32'hFFFF8001);
        check("unk_rt",   {27'd0, ID_EX_instr_2016}, 32'd3);
        check("unk_rd",   {27'd0, ID_EX_instr_1511}, 32'd16);

        // Reset mid-stream, then resume
        IF_ID_instr = 32'h00430820;
        IF_ID_npc   = 32'd7;
        rst_n       = 1'b0;
        step();
        check("mrst_wb",  {30'd0, ID_EX_wb}, 32'd0);
        check("mrst_ex",  {28'd0, ID_EX_ex}, 32'd0);
        check("mrst_npc", ID_EX_npc, 32'd0);
        rst_n = 1'b1;
        step();
        check("resume_wb",  {30'd0, ID_EX_wb}, 32'b10);
        check("resume_npc", ID_EX_npc, 32'd7);
        check("resume_rd1", ID_EX_readdat1, 32'd0);
        check("resume_rd2", ID_EX_readdat2, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
